dma_sd_wr: RTL and testbench

- DMA engine for the SD-card write path: RAM to SD card, one 512-byte block per start.
- Fetches one full block from RAM over the DMA sequencer into an internal buffer, then transmits it through the SD SPI byte module.
- Transmit frame: start token 0xFE, 512 data bytes, 2 CRC bytes, then collects the data-response token and waits out card busy.
- Programmed from ports.v through the same 4-register window as the SD read DMA.

---
 rtl/dma_sd_wr.sv | 248 ++++++++++++++++++++++++
 tb/tb_dma_sd_wr.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_sd_wr.sv
// rtl/dma_sd_wr.sv - RAM-to-SD-card single 512-byte block write DMA
//
// Fetches one block from RAM into an internal buffer, then sends it to the
// card as: 0xFE token, data bytes, two CRC bytes, response poll, busy wait.
// Optional build macro: DMA_SD_WR_CRC_EN (CRC16-CCITT over the data bytes;
// when undefined both CRC bytes are sent as 0xFF).
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   sd_start/sd_senddata          one-cycle byte-exchange request to SPI engine
//   sd_rdy/sd_recvdata            SPI engine idle flag and last received byte
//   din/dout/regsel               register window: 00 HAD, 01 MAD, 10 LAD, 11 CST
//   module_select/write_strobe    register write qualifier
//   dma_addr/dma_rnw/dma_req      DMA sequencer read request side
//   dma_ack/dma_end/dma_rd        DMA sequencer accept / data-return side
module dma_sd_wr #(
    parameter int BLK_LOG2   = 9,
    parameter int RESP_TRIES = 8
) (
    input  logic        clk,
    input  logic        rst,
    output logic        sd_start,
    output logic [7:0]  sd_senddata,
    input  logic        sd_rdy,
    input  logic [7:0]  sd_recvdata,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    input  logic        module_select,
    input  logic        write_strobe,
    input  logic [1:0]  regsel,
    output logic [21:0] dma_addr,
    input  logic [7:0]  dma_rd,
    output logic        dma_rnw,
    output logic        dma_req,
    input  logic        dma_ack,
    input  logic        dma_end
);

    localparam int BLK_LEN = 1 << BLK_LOG2;
    localparam int CW      = BLK_LOG2 + 1;
    localparam int TW      = $clog2(RESP_TRIES + 1);
    localparam logic [CW-1:0] BLK_CNT  = CW'(BLK_LEN);
    localparam logic [TW-1:0] TRY_LAST = TW'(RESP_TRIES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_TOK1, S_TOK2, S_DAT1, S_DAT2,
        S_CRC1, S_CRC1W, S_CRC2, S_CRC2W, S_RSP1, S_RSP2,
        S_BSY1, S_BSY2, S_ERR, S_STOP
    } state_t;

    state_t          state_q, state_d;
    logic            dma_on_q;
    logic [21:0]     addr_q;
    logic [2:0]      status_q;
    logic            err_q;
    logic [CW-1:0]   issued_q;   // requests accepted in this block
    logic [CW-1:0]   wptr_q;     // bytes stored in the buffer
    logic [CW-1:0]   rptr_q;     // bytes sent to the card
    logic [TW-1:0]   tries_q;
    logic [7:0]      buf_mem [BLK_LEN];
    logic [7:0]      crc_hi, crc_lo;

    logic reg_wr, req_ack, buf_wr, resp_ok, clr_ptrs;
    logic [7:0] rd_byte;
    logic unused_din;

    assign reg_wr   = module_select & write_strobe;
    assign req_ack  = dma_req & dma_ack;
    assign buf_wr   = (state_q == S_FETCH) && dma_on_q && dma_end && (wptr_q != BLK_CNT);
    // Data-response token format: xxx0sss1
    assign resp_ok  = !sd_recvdata[4] && sd_recvdata[0];
    assign rd_byte  = buf_mem[rptr_q[BLK_LOG2-1:0]];
    // An abort resets the pointers on the same clock that returns the FSM to IDLE.
    assign clr_ptrs = (state_q == S_IDLE) || !dma_on_q;
    assign dma_rnw  = 1'b1;
    assign dma_addr = addr_q;
    assign unused_din = din[6];

    always_comb begin
        dout = 8'h00;
        case (regsel)
            2'b00:   dout = {2'b00, addr_q[21:16]};
            2'b01:   dout = addr_q[15:8];
            2'b10:   dout = addr_q[7:0];
            default: dout = {dma_on_q, err_q, status_q, 3'b000};
        endcase
    end

    // Issue states only pulse sd_start once the SPI engine is idle, so a byte
    // left in flight by an abort can never be overlapped.
    always_comb begin
        state_d     = state_q;
        sd_start    = 1'b0;
        sd_senddata = 8'hFF;
        dma_req     = 1'b0;
        case (state_q)
            S_IDLE:  if (dma_on_q) state_d = S_FETCH;
            S_FETCH: begin
                dma_req = (issued_q < BLK_CNT);
                if (wptr_q == BLK_CNT) state_d = S_TOK1;
            end
            S_TOK1: if (sd_rdy) begin
                sd_start    = 1'b1;
                sd_senddata = 8'hFE;
                state_d     = S_TOK2;
            end
            S_TOK2: if (sd_rdy) state_d = S_DAT1;
            S_DAT1: if (sd_rdy) begin
                sd_start    = 1'b1;
                sd_senddata = rd_byte;
                state_d     = S_DAT2;
            end
            S_DAT2: if (sd_rdy) state_d = (rptr_q == BLK_CNT) ? S_CRC1 : S_DAT1;
            S_CRC1: if (sd_rdy) begin
                sd_start    = 1'b1;
                sd_senddata = crc_hi;
                state_d     = S_CRC1W;
            end
            S_CRC1W: if (sd_rdy) state_d = S_CRC2;
            S_CRC2: if (sd_rdy) begin
                sd_start    = 1'b1;
                sd_senddata = crc_lo;
                state_d     = S_CRC2W;
            end
            S_CRC2W: if (sd_rdy) state_d = S_RSP1;
            S_RSP1: if (sd_rdy) begin
                sd_start = 1'b1;
                state_d  = S_RSP2;
            end
            S_RSP2: if (sd_rdy) begin
                if (resp_ok)
                    state_d = (sd_recvdata[3:1] == 3'b010) ? S_BSY1 : S_ERR;
                else if (tries_q == TRY_LAST)
                    state_d = S_ERR;
                else
                    state_d = S_RSP1;
            end
            S_BSY1: if (sd_rdy) begin
                sd_start = 1'b1;
                state_d  = S_BSY2;
            end
            S_BSY2: if (sd_rdy) state_d = (sd_recvdata == 8'hFF) ? S_STOP : S_BSY1;
            S_ERR:   state_d = S_STOP;
            S_STOP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (!dma_on_q) begin
            state_d     = S_IDLE;
            sd_start    = 1'b0;
            sd_senddata = 8'hFF;
            dma_req     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            issued_q <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            tries_q  <= '0;
        end else begin
            state_q <= state_d;
            if (clr_ptrs) begin
                issued_q <= '0;
                wptr_q   <= '0;
                rptr_q   <= '0;
                tries_q  <= '0;
            end else begin
                if (req_ack) issued_q <= issued_q + CW'(1);
                if (buf_wr) wptr_q <= wptr_q + CW'(1);
                if (sd_start && state_q == S_DAT1) rptr_q <= rptr_q + CW'(1);
                if (state_q == S_RSP2 && sd_rdy && !resp_ok) tries_q <= tries_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (buf_wr) buf_mem[wptr_q[BLK_LOG2-1:0]] <= dma_rd;
    end

    // Register file; the register write is applied last so a CST write wins
    // over FSM-driven status updates in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dma_on_q <= 1'b0;
            addr_q   <= '0;
            status_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (req_ack) begin
                addr_q <= addr_q + 22'd1;
            end else if (reg_wr) begin
                case (regsel)
                    2'b00:   addr_q[21:16] <= din[5:0];
                    2'b01:   addr_q[15:8]  <= din;
                    2'b10:   addr_q[7:0]   <= din;
                    default: ;
                endcase
            end
            if (dma_on_q && state_q == S_RSP2 && sd_rdy) begin
                if (resp_ok) status_q <= sd_recvdata[3:1];
                else if (tries_q == TRY_LAST) status_q <= 3'b111;
            end
            if (dma_on_q && state_q == S_ERR) err_q <= 1'b1;
            if (state_q == S_STOP) dma_on_q <= 1'b0;
            if (reg_wr && regsel == 2'b11) begin
                dma_on_q <= din[7];
                if (din[7]) begin
                    err_q    <= 1'b0;
                    status_q <= 3'b000;
                end
            end
        end
    end

`ifdef DMA_SD_WR_CRC_EN
    logic [15:0] crc_q;

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    // Updated with each data byte at the moment it is handed to the SPI engine.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= 16'h0000;
        end else if (clr_ptrs) begin
            crc_q <= 16'h0000;
        end else if (sd_start && state_q == S_DAT1) begin
            crc_q <= crc16_byte(crc_q, rd_byte);
        end
    end

    assign crc_hi = crc_q[15:8];
    assign crc_lo = crc_q[7:0];
`else
    assign crc_hi = 8'hFF;
    assign crc_lo = 8'hFF;
`endif

endmodule

// File: tb/tb_dma_sd_wr.sv
// tb/tb_dma_sd_wr.sv - directed self-checking bench for dma_sd_wr
module tb_dma_sd_wr;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sd_start;
    logic [7:0]  sd_senddata;
    logic        sd_rdy = 1'b1;
    logic [7:0]  sd_recvdata = 8'hFF;
    logic [7:0]  din = 8'h00;
    logic [7:0]  dout;
    logic        module_select = 1'b0;
    logic        write_strobe = 1'b0;
    logic [1:0]  regsel = 2'b11;
    logic [21:0] dma_addr;
    logic [7:0]  dma_rd = 8'h00;
    logic        dma_rnw;
    logic        dma_req;
    logic        dma_ack = 1'b1;
    logic        dma_end = 1'b0;

    always #5 clk = ~clk;

    dma_sd_wr dut (
        .clk(clk), .rst(rst),
        .sd_start(sd_start), .sd_senddata(sd_senddata),
        .sd_rdy(sd_rdy), .sd_recvdata(sd_recvdata),
        .din(din), .dout(dout),
        .module_select(module_select), .write_strobe(write_strobe), .regsel(regsel),
        .dma_addr(dma_addr), .dma_rd(dma_rd), .dma_rnw(dma_rnw),
        .dma_req(dma_req), .dma_ack(dma_ack), .dma_end(dma_end)
    );

`ifdef DMA_SD_WR_CRC_EN
    localparam logic [7:0] CRC_FF_HI = 8'h7F;
    localparam logic [7:0] CRC_FF_LO = 8'hA1;
`else
    localparam logic [7:0] CRC_FF_HI = 8'hFF;
    localparam logic [7:0] CRC_FF_LO = 8'hFF;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // SPI byte engine model: busy for two cycles after each start.
    logic [7:0] tx_log[$];
    logic [7:0] resp_q[$];
    int         start_busy_viol = 0;

    initial begin
        int busy = 0;
        logic st, rdy_s;
        logic [7:0] b, pend;
        pend = 8'hFF;
        forever begin
            @(posedge clk);
            st = sd_start; b = sd_senddata; rdy_s = sd_rdy;
            #1;
            if (st) begin
                if (!rdy_s) start_busy_viol++;
                if (tx_log.size() >= 515 && resp_q.size() > 0) pend = resp_q.pop_front();
                else pend = 8'hFF;
                tx_log.push_back(b);
                sd_rdy = 1'b0;
                busy = 2;
            end else if (busy > 0) begin
                busy--;
                if (busy == 0) begin
                    sd_rdy = 1'b1;
                    sd_recvdata = pend;
                end
            end
        end
    end

    // DMA sequencer / RAM model.
    int          cyc = 0;
    int          ack_cnt = 0;
    int          end_dly = 1;
    bit          stall_en = 0;
    bit          stall_done = 0;
    int          stall_left = 0;
    int          ram_mode = 0;      // 0: byte = (addr-base)[7:0]; 1: 0xFF
    logic [21:0] base = '0;
    int          due_q[$];
    logic [21:0] adr_q[$];

    function automatic logic [7:0] ram_byte(input logic [21:0] a);
        logic [21:0] d;
        d = a - base;
        return (ram_mode == 1) ? 8'hFF : d[7:0];
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (dma_req && dma_ack) begin
                ack_cnt++;
                due_q.push_back(cyc + end_dly);
                adr_q.push_back(dma_addr);
            end
            #1;
            dma_end = 1'b0;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                dma_end = 1'b1;
                dma_rd  = ram_byte(adr_q[0]);
                void'(due_q.pop_front());
                void'(adr_q.pop_front());
            end
            if (stall_en && !stall_done && ack_cnt >= 200) begin
                stall_left = 100;
                stall_done = 1;
            end
            if (stall_left > 0) begin
                dma_ack = 1'b0;
                stall_left--;
            end else begin
                dma_ack = 1'b1;
            end
        end
    end

    task automatic reg_write(input logic [1:0] sel, input logic [7:0] val);
        @(negedge clk);
        regsel = sel; din = val; module_select = 1'b1; write_strobe = 1'b1;
        @(negedge clk);
        module_select = 1'b0; write_strobe = 1'b0; regsel = 2'b11;
    endtask

    task automatic reg_read(input logic [1:0] sel, output logic [7:0] val);
        @(negedge clk);
        regsel = sel;
        #1 val = dout;
        regsel = 2'b11;
    endtask

    task automatic run_block(input string tag);
        int n;
        n = 0;
        tx_log.delete();
        ack_cnt = 0;
        base = dma_addr;
        reg_write(2'b11, 8'h80);
        while (dout[7] === 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, 32'(n < 20000), 32'd1);
    endtask

    task automatic frame_check(input string tag, input int exp_len, input int mode);
        int bad;
        logic [7:0] e;
        bit skip;
        bad = 0;
        for (int i = 0; i < tx_log.size(); i++) begin
            skip = 0;
            if (i == 0)        e = 8'hFE;
            else if (i <= 512) e = (mode == 1) ? 8'hFF : 8'(i - 1);
            else if (i == 513) e = (mode == 1) ? CRC_FF_HI : 8'hFF;
            else if (i == 514) e = (mode == 1) ? CRC_FF_LO : 8'hFF;
            else               e = 8'hFF;
`ifdef DMA_SD_WR_CRC_EN
            if ((i == 513 || i == 514) && mode == 0) skip = 1;
`endif
            if (!skip && tx_log[i] !== e) bad++;
        end
        check({tag, "_len"}, 32'(tx_log.size()), 32'(exp_len));
        check({tag, "_bad_bytes"}, 32'(bad), 32'd0);
    endtask

    initial begin
        logic [7:0] v;
        int n, snap;

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_sd_start", 32'(sd_start), 32'd0);
        check("rst_senddata", 32'(sd_senddata), 32'hFF);
        check("rst_dma_req", 32'(dma_req), 32'd0);
        check("rst_dma_rnw", 32'(dma_rnw), 32'd1);
        check("rst_dma_addr", 32'(dma_addr), 32'd0);
        reg_read(2'b11, v);
        check("rst_cst", 32'(v), 32'h00);

        // Address programming and readback
        reg_write(2'b00, 8'hC1);
        reg_write(2'b01, 8'h23);
        reg_write(2'b10, 8'h45);
        reg_read(2'b00, v);
        check("had_read", 32'(v), 32'h01);
        reg_read(2'b10, v);
        check("lad_read", 32'(v), 32'h45);

        // Good block: response 0xE5 then busy 00 00 00 FF
        resp_q = '{8'hE5, 8'h00, 8'h00, 8'h00};
        run_block("good");
        frame_check("good", 520, 0);
        check("good_addr", 32'(dma_addr), 32'h012545);
        check("good_acks", 32'(ack_cnt), 32'd512);
        reg_read(2'b11, v);
        check("good_cst", 32'(v), 32'h10);

        // Error token sss=101: no busy polling
        resp_q = '{8'hEB};
        run_block("tok_err");
        check("tok_err_len", 32'(tx_log.size()), 32'd516);
        reg_read(2'b11, v);
        check("tok_err_cst", 32'(v), 32'h68);

        // No response: timeout after 8 polls
        resp_q.delete();
        run_block("timeout");
        check("timeout_len", 32'(tx_log.size()), 32'd523);
        reg_read(2'b11, v);
        check("timeout_cst", 32'(v), 32'h78);

        // DMA stall and delayed data return
        end_dly = 3; stall_en = 1; stall_done = 0;
        resp_q = '{8'hE5};
        run_block("stall");
        frame_check("stall", 517, 0);
        check("stall_acks", 32'(ack_cnt), 32'd512);
        check("stall_req_low", 32'(dma_req), 32'd0);
        check("stall_done_seen", 32'(stall_done), 32'd1);
        end_dly = 1; stall_en = 0;

        // Abort during the data phase
        resp_q.delete();
        tx_log.delete();
        reg_write(2'b11, 8'h80);
        n = 0;
        while (tx_log.size() < 102 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached", 32'(tx_log.size() >= 102), 32'd1);
        reg_write(2'b11, 8'h00);
        snap = tx_log.size();
        repeat (20) @(negedge clk);
        check("abort_no_start", 32'(tx_log.size()), 32'(snap));
        check("abort_req_low", 32'(dma_req), 32'd0);
        reg_read(2'b11, v);
        check("abort_cst", 32'(v), 32'h00);

        resp_q = '{8'hE5};
        run_block("restart");
        frame_check("restart", 517, 0);
        check("restart_acks", 32'(ack_cnt), 32'd512);

        // All-0xFF block: CRC bytes
        ram_mode = 1;
        resp_q = '{8'hE5};
        run_block("ffblk");
        frame_check("ffblk", 517, 1);
        check("ffblk_crc_hi", 32'(tx_log.size() > 513 ? tx_log[513] : 8'h00), 32'(CRC_FF_HI));
        check("ffblk_crc_lo", 32'(tx_log.size() > 514 ? tx_log[514] : 8'h00), 32'(CRC_FF_LO));

        check("start_while_busy", 32'(start_busy_viol), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
